// File: rtl/jedro_1_defines.sv
// Shared widths and ALU operation encodings for the jedro_1 core.
package jedro_1_defines;

    localparam int DATA_WIDTH     = 32;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;

    // Encoding is {funct7[5], funct3}, so decode can pass instruction bits straight through.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

endpackage

// File: rtl/jedro1_alu.sv
// Single-cycle-latency ALU: result, equality/overflow flags and the write-back
// tag are all registered together so they leave the stage aligned.
module jedro1_alu
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH = jedro_1_defines::DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [ALU_OP_WIDTH-1:0]   sel_i,
    input  logic [DATA_WIDTH-1:0]     op_a_i,
    input  logic [DATA_WIDTH-1:0]     op_b_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_addr_i,
    input  logic                      wb_i,
    output logic [DATA_WIDTH-1:0]     res_ro,
    output logic                      ops_eq_ro,
    output logic                      overflow_ro,
    output logic [REG_ADDR_WIDTH-1:0] dest_addr_ro,
    output logic                      wb_ro
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  ops_eq_d;
    logic                  overflow_d;

    assign sum   = op_a_i + op_b_i;
    assign diff  = op_a_i - op_b_i;
    assign shamt = op_b_i[4:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res_d      = '0;
        overflow_d = 1'b0;
        ops_eq_d   = (op_a_i == op_b_i);
        case (sel_i)
            ALU_ADD: begin
                res_d      = sum;
                overflow_d = (op_a_i[MSB] == op_b_i[MSB]) && (sum[MSB] != op_a_i[MSB]);
            end
            ALU_SUB: begin
                res_d      = diff;
                overflow_d = (op_a_i[MSB] != op_b_i[MSB]) && (diff[MSB] != op_a_i[MSB]);
            end
            ALU_SLL:  res_d = op_a_i << shamt;
            ALU_SRL:  res_d = op_a_i >> shamt;
            ALU_SRA:  res_d = $unsigned($signed(op_a_i) >>> shamt);
            ALU_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            ALU_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
            ALU_XOR:  res_d = op_a_i ^ op_b_i;
            ALU_OR:   res_d = op_a_i | op_b_i;
            ALU_AND:  res_d = op_a_i & op_b_i;
            default:  res_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an async active-low clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_ro       <= '0;
            ops_eq_ro    <= 1'b0;
            overflow_ro  <= 1'b0;
            dest_addr_ro <= '0;
            wb_ro        <= 1'b0;
        end else begin
            res_ro       <= res_d;
            ops_eq_ro    <= ops_eq_d;
            overflow_ro  <= overflow_d;
            dest_addr_ro <= dest_addr_i;
            wb_ro        <= wb_i;
        end
    end

endmodule

// File: tb/tb_jedro1_alu.sv
// Directed-vector bench for jedro1_alu with hand-computed expectations.
module tb_jedro1_alu;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  sel_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  dest_addr_i;
    logic        wb_i;
    logic [31:0] res_ro;
    logic        ops_eq_ro;
    logic        overflow_ro;
    logic [4:0]  dest_addr_ro;
    logic        wb_ro;

    int checks   = 0;
    int failures = 0;

    jedro1_alu #(.DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sel_i        (sel_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .dest_addr_i  (dest_addr_i),
        .wb_i         (wb_i),
        .res_ro       (res_ro),
        .ops_eq_ro    (ops_eq_ro),
        .overflow_ro  (overflow_ro),
        .dest_addr_ro (dest_addr_ro),
        .wb_ro        (wb_ro)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic wb);
        @(negedge clk_i);
        sel_i       = sel;
        op_a_i      = a;
        op_b_i      = b;
        dest_addr_i = dest;
        wb_i        = wb;
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic eq,
                              input logic ovf);
        check({tag, ".res"}, res_ro, res);
        check({tag, ".eq"},  {31'd0, ops_eq_ro}, {31'd0, eq});
        check({tag, ".ovf"}, {31'd0, overflow_ro}, {31'd0, ovf});
    endtask

    initial begin
        rstn_i      = 1'b0;
        sel_i       = 4'b0000;
        op_a_i      = 32'd3;
        op_b_i      = 32'd3;
        dest_addr_i = 5'd7;
        wb_i        = 1'b1;
        #2;
        expect_out("reset_init", 32'd0, 1'b0, 1'b0);
        check("reset_init.dest", {27'd0, dest_addr_ro}, 32'd0);
        check("reset_init.wb",   {31'd0, wb_ro}, 32'd0);
        @(posedge clk_i);
        #1;
        expect_out("reset_edge", 32'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        apply(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        apply(4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("add_wrap", 32'h0, 1'b0, 1'b0);
        apply(4'b1000, 32'd5, 32'd7, 5'd1, 1'b0);
        expect_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
        apply(4'b1000, 32'h8000_0000, 32'h1, 5'd1, 1'b0);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        apply(4'b0001, 32'h8000_0000, 32'h21, 5'd1, 1'b0);
        expect_out("sll", 32'h0, 1'b0, 1'b0);
        apply(4'b0101, 32'h8000_0000, 32'h21, 5'd1, 1'b0);
        expect_out("srl", 32'h4000_0000, 1'b0, 1'b0);
        apply(4'b1101, 32'h8000_0000, 32'h21, 5'd1, 1'b0);
        expect_out("sra", 32'hC000_0000, 1'b0, 1'b0);
        apply(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("slt", 32'h1, 1'b0, 1'b0);
        apply(4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("sltu", 32'h0, 1'b0, 1'b0);
        apply(4'b0100, 32'h1234, 32'h1234, 5'd1, 1'b0);
        expect_out("xor_eq", 32'h0, 1'b1, 1'b0);
        apply(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 5'd1, 1'b0);
        expect_out("or", 32'hF0F0_0F0F, 1'b0, 1'b0);
        apply(4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd1, 1'b0);
        expect_out("and", 32'h0F00_0F00, 1'b0, 1'b0);
        apply(4'b1111, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("undef_f", 32'h0, 1'b0, 1'b0);
        apply(4'b1001, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b0);
        expect_out("undef_9", 32'h0, 1'b0, 1'b0);
        apply(4'b1110, 32'hABCD, 32'hABCD, 5'd1, 1'b0);
        expect_out("undef_eq", 32'h0, 1'b1, 1'b0);

        // Tag alignment, then a one-cycle latency probe before the next edge.
        apply(4'b0000, 32'd10, 32'd20, 5'd9, 1'b1);
        expect_out("tag9", 32'd30, 1'b0, 1'b0);
        check("tag9.dest", {27'd0, dest_addr_ro}, 32'd9);
        check("tag9.wb",   {31'd0, wb_ro}, 32'd1);
        @(negedge clk_i);
        sel_i       = 4'b0000;
        op_a_i      = 32'd1;
        op_b_i      = 32'd1;
        dest_addr_i = 5'd0;
        wb_i        = 1'b1;
        #1;
        check("latency.hold", res_ro, 32'd30);
        @(posedge clk_i);
        #1;
        check("x0.res",  res_ro, 32'd2);
        check("x0.dest", {27'd0, dest_addr_ro}, 32'd0);
        check("x0.wb",   {31'd0, wb_ro}, 32'd1);

        // Asynchronous reset mid-cycle, held across an edge, then release.
        apply(4'b0110, 32'h5555_0000, 32'h0000_AAAA, 5'd17, 1'b1);
        expect_out("pre_rst", 32'h5555_AAAA, 1'b0, 1'b0);
        #2;
        rstn_i = 1'b0;
        #1;
        expect_out("async_rst", 32'h0, 1'b0, 1'b0);
        check("async_rst.dest", {27'd0, dest_addr_ro}, 32'd0);
        check("async_rst.wb",   {31'd0, wb_ro}, 32'd0);
        @(posedge clk_i);
        #1;
        check("rst_hold.res", res_ro, 32'd0);
        @(negedge clk_i);
        sel_i       = 4'b0000;
        op_a_i      = 32'd2;
        op_b_i      = 32'd3;
        dest_addr_i = 5'd4;
        wb_i        = 1'b1;
        rstn_i      = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst.res",  res_ro, 32'd5);
        check("post_rst.dest", {27'd0, dest_addr_ro}, 32'd4);
        check("post_rst.wb",   {31'd0, wb_ro}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jedro1_alu.md
JEDRO1_ALU -- requirements
Module: jedro1_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width; ALU_OP_WIDTH = 4 and REG_ADDR_WIDTH = 5 come from jedro_1_defines.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 sel_i  in  ALU_OP_WIDTH  operation select.
REQ-005 op_a_i  in  DATA_WIDTH  operand A (register or PC).
REQ-006 op_b_i  in  DATA_WIDTH  operand B (register or immediate).
REQ-007 res_ro  out  DATA_WIDTH  registered result.
REQ-008 ops_eq_ro  out  1  registered op_a_i == op_b_i.
REQ-009 overflow_ro  out  1  registered signed overflow of ADD/SUB.
REQ-010 dest_addr_i  in  REG_ADDR_WIDTH  destination register; dest_addr_ro  out  REG_ADDR_WIDTH  registered copy.
REQ-011 wb_i  in  1  write-back request; wb_ro  out  1  registered copy.

Function
REQ-012 All outputs SHALL be flops updated on every rising clk_i; latency exactly 1 cycle; no stall/handshake, no enable.
REQ-013 sel_i encoding = {funct7[5], funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-014 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH (carry-out discarded).
REQ-015 SLL/SRL/SRA SHALL shift op_a_i by op_b_i[4:0] only; SRA sign-fills from op_a_i[31].
REQ-016 SLT (signed) / SLTU (unsigned) SHALL give 32'd1 if op_a_i < op_b_i else 32'd0.
REQ-017 Any undefined sel_i code SHALL give res 0 and overflow 0.
REQ-018 overflow_ro SHALL be 1 only for ADD when both operands share a sign differing from the result's, or for SUB when operand signs differ and the result's sign differs from op_a_i's; 0 for all other ops.
REQ-019 ops_eq_ro SHALL be computed for every sel_i value, independent of the operation.
REQ-020 dest_addr_ro and wb_ro SHALL pass dest_addr_i/wb_i unchanged with the same 1-cycle delay as res_ro, so result and tag stay aligned.
REQ-021 wb_i = 1 with dest_addr_i = 0 SHALL still propagate unchanged; x0 suppression belongs to the register file.

Reset
REQ-022 While rstn_i = 0, res_ro = 0, ops_eq_ro = 0, overflow_ro = 0, dest_addr_ro = 0, wb_ro = 0 immediately, independent of clk_i.
REQ-023 A reset asserted mid-stream SHALL discard the in-flight result; the first clock edge after deassertion SHALL register the then-current inputs.

Structure
REQ-024 ALU op encodings (localparams or enum), ALU_OP_WIDTH, REG_ADDR_WIDTH and DATA_WIDTH SHALL live in package jedro_1_defines.
REQ-025 One combinational always block computes the next result/flags; one sequential block registers them; no sub-modules.

Verification
REQ-026 ADD: a = 32'h7FFF_FFFF, b = 1 -> next cycle res = 32'h8000_0000, overflow = 1; a = 32'hFFFF_FFFF, b = 1 -> res = 0, overflow = 0.
REQ-027 SUB: a = 5, b = 7 -> res = 32'hFFFF_FFFE; a = 32'h8000_0000, b = 1 -> res = 32'h7FFF_FFFF, overflow = 1.
REQ-028 Shifts: a = 32'h8000_0000, b = 32'h21 -> SLL res = 0, SRL res = 32'h4000_0000, SRA res = 32'hC000_0000.
REQ-029 Compare: a = 32'hFFFF_FFFF, b = 1 -> SLT res = 1, SLTU res = 0; a = b = 32'h1234 -> ops_eq = 1.
REQ-030 Pipeline tags: dest_addr_i = 5'd9 and wb_i = 1 at edge N -> dest_addr_ro = 9 and wb_ro = 1 after edge N, aligned with res_ro.
REQ-031 Reset: drive rstn_i low between clock edges -> all outputs 0 without waiting for a clock edge; sel_i = 4'b1111 -> res = 0.
